// File: rtl/n_bit_comparator_if.sv
// Valid-qualified operand/result bundle for n_bit_comparator.
// min/max result lanes exist only when COMPARATOR_MINMAX_EN is defined.
interface n_bit_comparator_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             smaller;
    logic             equal;
    logic             bigger;

`ifdef COMPARATOR_MINMAX_EN
    logic [WIDTH-1:0] max_out;
    logic [WIDTH-1:0] min_out;

    modport master (
        output in_valid, a, b, signed_mode,
        input  out_valid, smaller, equal, bigger, max_out, min_out
    );

    modport slave (
        input  in_valid, a, b, signed_mode,
        output out_valid, smaller, equal, bigger, max_out, min_out
    );
`else
    modport master (
        output in_valid, a, b, signed_mode,
        input  out_valid, smaller, equal, bigger
    );

    modport slave (
        input  in_valid, a, b, signed_mode,
        output out_valid, smaller, equal, bigger
    );
`endif

endinterface

// File: rtl/n_bit_comparator.sv
// Registered one-cycle magnitude comparator, unsigned or two's-complement per transaction.
// Optional max_out/min_out result lanes are enabled by defining COMPARATOR_MINMAX_EN.
module n_bit_comparator #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    n_bit_comparator_if.slave  bus
);

    logic a_less;
    logic a_equal;

    // equal is the same bit pattern test in both modes; only ordering depends on signed_mode
    always_comb begin
        a_equal = (bus.a == bus.b);
        if (bus.signed_mode) begin
            a_less = ($signed(bus.a) < $signed(bus.b));
        end else begin
            a_less = (bus.a < bus.b);
        end
    end

    // Flags (and min/max) only load on accepted inputs so they hold while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.smaller   <= 1'b0;
            bus.equal     <= 1'b0;
            bus.bigger    <= 1'b0;
`ifdef COMPARATOR_MINMAX_EN
            bus.max_out   <= '0;
            bus.min_out   <= '0;
`endif
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.smaller <= a_less;
                bus.equal   <= a_equal;
                bus.bigger  <= !a_less && !a_equal;
`ifdef COMPARATOR_MINMAX_EN
                bus.max_out <= a_less ? bus.b : bus.a;
                bus.min_out <= (a_less || a_equal) ? bus.a : bus.b;
`endif
            end
        end
    end

endmodule

// File: tb/tb_n_bit_comparator.sv
// Directed scoreboard bench for n_bit_comparator at WIDTH=8.
// Define COMPARATOR_MINMAX_EN for both DUT and bench to also cover max_out/min_out.
module tb_n_bit_comparator;

    localparam int WIDTH = 8;

    typedef struct {
        logic             smaller;
        logic             equal;
        logic             bigger;
        logic [WIDTH-1:0] maxv;
        logic [WIDTH-1:0] minv;
    } result_t;

    logic clk;
    logic rst_n;

    n_bit_comparator_if #(.WIDTH(WIDTH)) bus ();

    n_bit_comparator #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    result_t expQueue[$];
    result_t lastResult;
    int      assertCount = 0;
    int      failCount   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input longint observed, input longint expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Independent reference: interpret operands as plain integers, then order them
    function automatic result_t model(input int aIn, input int bIn, input logic sm);
        result_t r;
        longint av;
        longint bv;
        av = aIn & 255;
        bv = bIn & 255;
        if (sm && av >= 128) av = av - 256;
        if (sm && bv >= 128) bv = bv - 256;
        r.smaller = (av < bv);
        r.equal   = (av == bv);
        r.bigger  = (av > bv);
        r.maxv    = (av < bv) ? WIDTH'(bIn) : WIDTH'(aIn);
        r.minv    = (av > bv) ? WIDTH'(bIn) : WIDTH'(aIn);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic expValid);
        result_t e;
        int hot;
        checkVal({tag, ".out_valid"}, longint'(bus.out_valid), longint'(expValid));
        if (expValid) begin
            if (expQueue.size() == 0) begin
                checkVal({tag, ".queue_empty"}, 1, 0);
                return;
            end
            e = expQueue.pop_front();
            lastResult = e;
            hot = int'(bus.smaller) + int'(bus.equal) + int'(bus.bigger);
            checkVal({tag, ".onehot"}, hot, 1);
        end else begin
            e = lastResult;
        end
        checkVal({tag, ".smaller"}, longint'(bus.smaller), longint'(e.smaller));
        checkVal({tag, ".equal"},   longint'(bus.equal),   longint'(e.equal));
        checkVal({tag, ".bigger"},  longint'(bus.bigger),  longint'(e.bigger));
`ifdef COMPARATOR_MINMAX_EN
        checkVal({tag, ".max_out"}, longint'(bus.max_out), longint'(e.maxv));
        checkVal({tag, ".min_out"}, longint'(bus.min_out), longint'(e.minv));
`endif
    endtask

    // One clock: drive at negedge, sample 1 after posedge
    task automatic applyStimulus(input string tag, input logic v, input int aIn, input int bIn, input logic sm);
        int aT;
        int bT;
        aT = aIn;
        bT = bIn;
        @(negedge clk);
        bus.in_valid    = v;
        bus.a           = aT[WIDTH-1:0];
        bus.b           = bT[WIDTH-1:0];
        bus.signed_mode = sm;
        if (v) expQueue.push_back(model(aIn, bIn, sm));
        @(posedge clk);
        #1;
        checkOutput(tag, v);
    endtask

    task automatic clearModel();
        expQueue.delete();
        lastResult = '{1'b0, 1'b0, 1'b0, '0, '0};
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.signed_mode = 1'b0;
        clearModel();

        // Reset held, including an in_valid pulse that must be ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = (i == 1);
            bus.a        = 8'd3;
            bus.b        = 8'd7;
            @(posedge clk);
            #1;
            checkOutput("reset_hold", 1'b0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;

        // Back-to-back with truncated operands
        applyStimulus("b2b0", 1'b1, 123, 235, 1'b0);
        applyStimulus("b2b1", 1'b1, 365, 267, 1'b0);
        applyStimulus("b2b2", 1'b1, 147, 659, 1'b0);
        applyStimulus("b2b3", 1'b1, 300, 500, 1'b0);

        // Signed mode
        applyStimulus("sgn_80_7f",  1'b1, 8'h80, 8'h7F, 1'b1);
        applyStimulus("uns_80_7f",  1'b1, 8'h80, 8'h7F, 1'b0);
        applyStimulus("sgn_ff_ff",  1'b1, 8'hFF, 8'hFF, 1'b1);
        applyStimulus("sgn_f0_10",  1'b1, 8'hF0, 8'h10, 1'b1);
        applyStimulus("uns_200_17", 1'b1, 200, 17, 1'b0);

        // Idle hold
        applyStimulus("hold_load", 1'b1, 5, 9, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("hold_idle", 1'b0, 0, 0, 1'b0);

        // Boundaries
        applyStimulus("bnd_0_255", 1'b1, 0, 255, 1'b0);
        applyStimulus("bnd_255_0", 1'b1, 255, 0, 1'b0);
        applyStimulus("bnd_0_0",   1'b1, 0, 0, 1'b0);

        // Asynchronous reset mid-cycle clears outputs with no clock edge
        applyStimulus("pre_async", 1'b1, 250, 4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        clearModel();
        checkOutput("async_clear", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // A result pending when reset falls is discarded
        bus.in_valid = 1'b1;
        bus.a        = 8'd1;
        bus.b        = 8'd2;
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pending_drop", 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        applyStimulus("post_reset_idle", 1'b0, 0, 0, 1'b0);
        applyStimulus("post_reset_run",  1'b1, 77, 76, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/n_bit_comparator.md
Name: n_bit_comparator

Overview:
- Registered magnitude comparator for two WIDTH-bit operands a and b.
- Produces one-hot flags smaller, equal and bigger, each 1 clock after an accepted input.
- Supports unsigned or two's-complement operands, selected per transaction.
- Used as a datapath compare stage behind a simple valid-qualified interface.

Parameters:
- WIDTH, 8, operand width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion clears state immediately, deassertion is synchronised externally.
- in_valid  input  1  qualifies a, b and signed_mode for the current cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare.
- out_valid  output  1  high for exactly one cycle per accepted input, one cycle after it.
- smaller  output  1  A < B.
- equal  output  1  A == B.
- bigger  output  1  A > B.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, smaller=0, equal=0, bigger=0; any optional registers are cleared to 0.
- Accept: on a rising clk edge with in_valid=1, compute the compare from the current a, b and signed_mode, and register the flags.
- Latency: 1 cycle. On the next edge, out_valid=1 and the flags reflect the accepted operands.
- Throughput: one compare per cycle. Back-to-back in_valid produces back-to-back out_valid.
- No backpressure: there is no ready signal, and every in_valid cycle is accepted.
- Idle: with in_valid=0, out_valid is 0 on the next edge. smaller, equal and bigger hold their last values, so a consumer must qualify them with out_valid.
- One-hot: after the first accepted input, exactly one of smaller, equal, bigger is 1. All three are 0 only between reset and the first result.
- Unsigned mode: plain magnitude compare of the WIDTH-bit values. Operands wider than WIDTH are truncated to their low WIDTH bits by the driver before reaching the ports.
- Signed mode: MSB is the sign bit. Example for WIDTH=8: 8'h80 (-128) < 8'h7F (+127).
- equal is independent of signed_mode.
- WIDTH=1 signed: 1'b1 = -1 < 1'b0 = 0.
- Reset mid-operation: a result pending on the edge where rst_n falls is discarded; out_valid is 0 after reset releases.
- No X propagation: outputs are driven from registers only.

Optional Feature:
- Macro: COMPARATOR_MINMAX_EN.
- When defined:
  - Adds outputs max_out [WIDTH-1:0] and min_out [WIDTH-1:0], registered alongside the flags with the same 1-cycle latency and the same hold behaviour.
  - max_out is the larger operand under the active signed_mode; min_out is the smaller.
  - On equal operands, both outputs take the value of a.
  - Both reset to 0.
- When undefined: the ports are absent and no extra logic is generated. Flag behaviour is identical in both builds.

Test Plan (WIDTH=8, signed_mode=0 unless stated):
- Reset: hold rst_n=0 for several cycles, including one in_valid pulse -> out_valid=0 and all flags 0. Asserting rst_n low asynchronously mid-cycle clears the outputs without a clock edge.
- Back-to-back sequence, one per cycle:
  - a=123, b=235 -> smaller=1.
  - a=109 (365 truncated), b=11 (267 truncated) -> bigger=1.
  - a=147, b=147 (659 truncated) -> equal=1.
  - a=44, b=244 (300/500 truncated) -> smaller=1.
  - Required: out_valid high on four consecutive cycles, each result one cycle after its input.
- Signed mode:
  - a=8'h80, b=8'h7F, signed_mode=1 -> smaller=1.
  - Same operands with signed_mode=0 -> bigger=1.
  - a=8'hFF, b=8'hFF, signed_mode=1 -> equal=1.
- Idle hold: after a=5, b=9, drop in_valid for 3 cycles -> out_valid=0, smaller stays 1.
- Boundaries:
  - a=0, b=255 -> smaller=1.
  - a=255, b=0 -> bigger=1.
  - a=0, b=0 -> equal=1.
  - Required in every case: exactly one flag set.
- With COMPARATOR_MINMAX_EN:
  - a=200, b=17 -> max_out=200, min_out=17.
  - Signed, a=8'hF0, b=8'h10 -> max_out=8'h10, min_out=8'hF0.
